// File: rtl/cnt_sample_uart_tx_pkg.sv
// Shared definitions for the counter-sample UART transmitter.
//  - state_e : FSM state encoding (3 bits)
//  - FRAME_BITS / DATA_BITS : UART 8N1 frame geometry
package cnt_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_e;

    localparam int FRAME_BITS = 10;  // start + 8 data + stop
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/cnt_sample_uart_tx_if.sv
// Bus between the counter/UART consumer and whoever drives it.
//  ena, cnt_in, sample_req : requester -> block
//  tx, busy, tx_done, sample_err : block -> requester / board
// master = driving side (bench or SoC glue), slave = cnt_sample_uart_tx.
interface cnt_sample_uart_tx_if;
    logic       ena;
    logic [7:0] cnt_in;
    logic       sample_req;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic       sample_err;

    modport master (
        output ena, cnt_in, sample_req,
        input  tx, busy, tx_done, sample_err
    );

    modport slave (
        input  ena, cnt_in, sample_req,
        output tx, busy, tx_done, sample_err
    );
endinterface

// File: rtl/cnt_sample_uart_tx_sync_stable_filter.sv
// Synchroniser plus stability detector for the asynchronous 8-bit counter.
//  clk, rst : clock, synchronous active-high reset
//  d        : raw asynchronous counter value
//  q        : synchronised value (last sync stage)
//  stable   : q has matched its previous value long enough to be trusted
module sync_stable_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       stable
);
    localparam logic [3:0] STABLE_TH = 4'(STABLE_CNT);

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  prev_q, prev_d;
    logic [3:0]                  match_cnt_q, match_cnt_d;
    logic [7:0]                  cnt_s;

    assign cnt_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d = cnt_s;
        // Run length of identical synchronised samples, saturating at 15.
        if (cnt_s != prev_q)           match_cnt_d = 4'd0;
        else if (match_cnt_q != 4'd15) match_cnt_d = match_cnt_q + 4'd1;
        else                           match_cnt_d = match_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            prev_q      <= '0;
            match_cnt_q <= '0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign q      = cnt_s;
    assign stable = (match_cnt_q >= STABLE_TH);
endmodule

// File: rtl/cnt_sample_uart_tx.sv
// Captures the ring-oscillator count on request and sends it as one UART
// 8N1 frame.
//  clk, rst : clock, synchronous active-high reset
//  bus      : slave side of cnt_sample_uart_tx_if
//             (ena, cnt_in, sample_req in; tx, busy, tx_done, sample_err out)
module cnt_sample_uart_tx
    import cnt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_CNT   = 2,
    parameter int ARM_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    cnt_sample_uart_tx_if.slave   bus
);
    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] TMO_LIM   = 8'(ARM_TIMEOUT);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    state_e     state_q, state_d;
    logic [7:0] baud_q, baud_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] shreg_q, shreg_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       tx_done_q, tx_done_d;
    logic       err_q, err_d;

    logic [7:0] cnt_s;
    logic       stable;
    logic       baud_last;

    sync_stable_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .d      (bus.cnt_in),
        .q      (cnt_s),
        .stable (stable)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        tmo_d     = tmo_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        tx_done_d = 1'b0;
        err_d     = 1'b0;

        // The cycle that reports tx_done is still treated as busy, so a
        // request landing there is dropped rather than starting a new frame.
        if (bus.sample_req && (state_q != S_IDLE || tx_done_q)) err_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (bus.sample_req && bus.ena && !tx_done_q) begin
                    state_d = S_ARM;
                    tmo_d   = 8'd0;
                    busy_d  = 1'b1;
                end
            end
            S_ARM: begin
                if (!bus.ena) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (stable) begin
                    shreg_d = cnt_s;
                    baud_d  = 8'd0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end else if (tmo_q + 8'd1 == TMO_LIM) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d    = 8'd0;
                    bit_idx_d = 3'd0;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = 8'd0;
                    if (bit_idx_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d    = 8'd0;
                    busy_d    = 1'b0;
                    tx_done_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tmo_q     <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            tmo_q     <= tmo_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
            err_q     <= err_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.sample_err = err_q;
endmodule
